// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, FSM state type and
// the default WAIT-phase timeout derived from the operand width.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } seq_state_t;

  function automatic int default_timeout(input int n);
    return 2 * n + 8;
  endfunction

  function automatic logic is_div_by_zero(input logic [2:0] op, input logic is_zero_b);
    return (op == OP_DIV) && is_zero_b;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the command, ALU and response ports of the ALU op sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// the sender holds valid and payload stable until then, ready may toggle freely.
interface alu_op_sequencer_if #(
  parameter int N = 4
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [N-1:0]   cmd_a;
  logic [N-1:0]   cmd_b;

  logic [2:0]     alu_op;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [2*N-1:0] alu_result;
  logic           alu_valid;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*N-1:0] rsp_data;
  logic [2:0]     rsp_op;
  logic           rsp_timeout;
  logic           rsp_err;

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result, alu_valid,
    output rsp_valid, rsp_data, rsp_op, rsp_timeout, rsp_err,
    input  rsp_ready
  );

  // Command source / ALU / response consumer side.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result, alu_valid,
    input  rsp_valid, rsp_data, rsp_op, rsp_timeout, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_seq_timeout_ctr.sv
// Clearable up-counter bounding the WAIT phase; tc flags the last allowed
// cycle (count == TIMEOUT-1) and the counter stops there.
module alu_seq_timeout_ctr #(
  parameter int TIMEOUT = 16,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives one command at a time into the ALU and returns result/timeout/error.
// Optional statistics counters are enabled with ALU_SEQ_STATS_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = default_timeout(N)
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output seq_state_t          state
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]         stat_done,
  output logic [15:0]         stat_fault
`endif
);

  logic           cmd_ready_q;
  logic [2:0]     alu_op_q;
  logic [N-1:0]   alu_a_q;
  logic [N-1:0]   alu_b_q;
  logic           rsp_valid_q;
  logic [2*N-1:0] rsp_data_q;
  logic [2:0]     rsp_op_q;
  logic           rsp_timeout_q;
  logic           rsp_err_q;
  logic           tmo_tc;
  logic           tmo_clear;
  logic           tmo_en;
  logic           div_zero;

  assign div_zero  = is_div_by_zero(bus.cmd_op, bus.cmd_b == '0);
  assign tmo_clear = (state == SETTLE);
  assign tmo_en    = (state == WAIT) && !bus.alu_valid;

  alu_seq_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            rsp_op_q    <= bus.cmd_op;
            if (div_zero) begin
              // Rejected before reaching the ALU, so its inputs keep the previous command.
              rsp_valid_q   <= 1'b1;
              rsp_data_q    <= '0;
              rsp_timeout_q <= 1'b0;
              rsp_err_q     <= 1'b1;
              state         <= RESP;
            end else begin
              alu_op_q <= bus.cmd_op;
              alu_a_q  <= bus.cmd_a;
              alu_b_q  <= bus.cmd_b;
              state    <= SETTLE;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETTLE: begin
          // alu_valid here still reflects the previous operation.
          state <= WAIT;
        end
        WAIT: begin
          if (bus.alu_valid) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= bus.alu_result;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            state         <= RESP;
          end else if (tmo_tc) begin
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_err_q     <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_err     = rsp_err_q;

`ifdef ALU_SEQ_STATS_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done  <= '0;
      stat_fault <= '0;
    end else if (rsp_fire) begin
      if (rsp_timeout_q || rsp_err_q) begin
        if (stat_fault != 16'hFFFF) stat_fault <= stat_fault + 16'd1;
      end else begin
        if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer with a behavioural
// ALU responder and a spec-level response model.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int N       = 4;
  localparam int W       = 2 * N;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  seq_state_t dbg_state;
  int         vectors     = 0;
  int         miscompares = 0;

  // Model of what the ALU was last handed (reset clears it).
  logic [2:0]   cur_op = '0;
  logic [N-1:0] cur_a  = '0;
  logic [N-1:0] cur_b  = '0;
  logic [W-1:0] last_data;
  int           exp_done  = 0;
  int           exp_fault = 0;

  alu_op_sequencer_if #(.N(N)) bus ();

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_done;
  logic [15:0] stat_fault;
`endif

  alu_op_sequencer #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .state (dbg_state)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_done  (stat_done),
    .stat_fault (stat_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int sa;
    int sb;
    int r;
    logic [N-1:0] t;
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    case (op)
      OP_ADD: r = sa + sb;
      OP_SUB: r = sa - sb;
      OP_MUL: r = sa * sb;
      OP_DIV: r = (sb == 0) ? 0 : sa / sb;
      OP_AND: begin t = a & b; r = $signed(t); end
      OP_OR:  begin t = a | b; r = $signed(t); end
      OP_XOR: begin t = a ^ b; r = $signed(t); end
      default: begin t = ~a; r = $signed(t); end
    endcase
    return r[W-1:0];
  endfunction

  // One full command: accept in cycle 0, ALU answers (valid, sticky) from cycle lat.
  task automatic do_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [W-1:0] res, input int lat, input int rdy_delay);
    int           exp_cycle;
    logic [W-1:0] exp_data;
    logic         exp_to;
    logic         exp_err;
    logic [2:0]   exp_op;
    logic [N-1:0] exp_a;
    logic [N-1:0] exp_b;
    int           k;
    int           g;
    bit           seen;
    if (op == OP_DIV && b == '0) begin
      exp_cycle = 1; exp_data = '0; exp_to = 1'b0; exp_err = 1'b1;
      exp_op = cur_op; exp_a = cur_a; exp_b = cur_b;
    end else begin
      exp_op = op; exp_a = a; exp_b = b; exp_err = 1'b0;
      if (lat <= TIMEOUT + 1) begin
        exp_cycle = lat + 1; exp_data = res; exp_to = 1'b0;
      end else begin
        exp_cycle = TIMEOUT + 2; exp_data = '0; exp_to = 1'b1;
      end
    end
    g = 0;
    while (!bus.cmd_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < TIMEOUT + 10) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid) begin
        seen = 1'b1;
      end else begin
        check("cmd_ready_busy", bus.cmd_ready, 1'b0);
        check("alu_inputs", {bus.alu_op, bus.alu_a, bus.alu_b}, {exp_op, exp_a, exp_b});
        if (k == 1) begin
          check("settle_state", dbg_state, SETTLE);
        end
      end
      bus.cmd_valid = seen ? 1'b0 : 1'($urandom_range(0, 1));
      bus.cmd_op    = 3'($urandom);
      bus.cmd_a     = N'($urandom);
      bus.cmd_b     = N'($urandom);
      if (k >= 2) begin
        bus.alu_valid  = (k >= lat);
        bus.alu_result = (k >= lat) ? res : W'($urandom);
      end
    end
    check("rsp_cycle", k, exp_cycle);
    check("rsp_data", bus.rsp_data, exp_data);
    check("rsp_op", bus.rsp_op, op);
    check("rsp_flags", {bus.rsp_timeout, bus.rsp_err}, {exp_to, exp_err});
    check("alu_hold", {bus.alu_op, bus.alu_a, bus.alu_b}, {exp_op, exp_a, exp_b});
    last_data = bus.rsp_data;
    for (int i = 0; i < rdy_delay; i++) begin
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      check("rsp_hold_valid", {bus.rsp_valid, bus.cmd_ready}, 2'b10);
      check("rsp_hold_data", {bus.rsp_data, bus.rsp_op, bus.rsp_timeout, bus.rsp_err},
            {exp_data, op, exp_to, exp_err});
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_done", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    if (exp_to || exp_err) exp_fault++;
    else exp_done++;
    cur_op = exp_op;
    cur_a  = exp_a;
    cur_b  = exp_b;
  endtask

  initial begin
    logic [2:0]   r_op;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.alu_result = '0;
    bus.alu_valid  = 1'b0;
    bus.rsp_ready  = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_ready", bus.cmd_ready, 1'b0);
    check("reset_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'b0, N'(0), N'(0)});
    check("reset_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_op, bus.rsp_timeout, bus.rsp_err}, '0);
    check("reset_state", dbg_state, IDLE);
    rst = 1'b0;
    #1;
    check("ready_after_release", bus.cmd_ready, 1'b0);
    @(negedge clk);
    check("ready_first_cycle", bus.cmd_ready, 1'b1);

    // Directed cases
    do_cmd(OP_ADD, 4'd3, 4'd2, alu_fn(OP_ADD, 4'd3, 4'd2), 2, 0);
    check("add_value", last_data, 8'h05);
    do_cmd(OP_MUL, 4'hD, 4'd2, alu_fn(OP_MUL, 4'hD, 4'd2), 6, 1);
    check("mul_value", last_data, 8'hFA);
    do_cmd(OP_DIV, 4'd7, 4'd0, 8'h00, 2, 0);
    bus.alu_valid  = 1'b1;
    bus.alu_result = 8'h11;
    do_cmd(OP_XOR, 4'd3, 4'd1, 8'h22, 2, 0);
    check("stale_value", last_data, 8'h22);
    bus.alu_valid = 1'b0;
    do_cmd(OP_SUB, 4'd5, 4'd1, alu_fn(OP_SUB, 4'd5, 4'd1), 1000, 0);
    bus.alu_valid = 1'b0;
    do_cmd(OP_AND, 4'd6, 4'd3, alu_fn(OP_AND, 4'd6, 4'd3), TIMEOUT + 1, 0);
    bus.alu_valid = 1'b0;
    do_cmd(OP_SUB, 4'd2, 4'd4, alu_fn(OP_SUB, 4'd2, 4'd4), TIMEOUT + 2, 1);
    do_cmd(OP_OR, 4'h9, 4'h4, alu_fn(OP_OR, 4'h9, 4'h4), 3, 5);

    // Randomized commands
    for (int n = 0; n < 24; n++) begin
      r_op = 3'($urandom);
      r_a  = N'($urandom);
      r_b  = ($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom);
      do_cmd(r_op, r_a, r_b, alu_fn(r_op, r_a, r_b), $urandom_range(2, TIMEOUT + 3),
             $urandom_range(0, 3));
    end

    // Reset in the middle of WAIT drops the command
    check("pre_abort_ready", bus.cmd_ready, 1'b1);
    bus.alu_valid = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_MUL;
    bus.cmd_a     = 4'd5;
    bus.cmd_b     = 4'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_wait", dbg_state, WAIT);
    rst = 1'b1;
    #1;
    check("abort_ready", bus.cmd_ready, 1'b0);
    check("abort_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'b0, N'(0), N'(0)});
    check("abort_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_op, bus.rsp_timeout, bus.rsp_err}, '0);
    check("abort_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    exp_done  = 0;
    exp_fault = 0;
    cur_op = '0;
    cur_a  = '0;
    cur_b  = '0;
    bus.rsp_ready  = 1'b1;
    bus.alu_valid  = 1'b1;
    bus.alu_result = 8'h33;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_rsp_after_abort", bus.rsp_valid, 1'b0);
    end
    bus.rsp_ready = 1'b0;
    check("ready_after_abort", bus.cmd_ready, 1'b1);
    do_cmd(OP_NOT, 4'h5, 4'h0, alu_fn(OP_NOT, 4'h5, 4'h0), 4, 0);
    do_cmd(OP_DIV, 4'h6, 4'h0, 8'h00, 2, 2);

`ifdef ALU_SEQ_STATS_EN
    check("stat_done", stat_done, 16'(exp_done));
    check("stat_fault", stat_fault, 16'(exp_fault));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
